// File: rtl/noc_leaf_injector.sv
// Leaf injector: 2-entry in-order buffer feeding a credit-controlled NoC leaf port (stats via NOC_INJ_STATS_EN).
// Latency: 1 cycle from accept to tx when the buffer is empty and credit is available (fall-through head).
// Backpressure: in_ready drops when the buffer is full; a head without credit blocks every later entry.
module noc_leaf_injector #(
  parameter int N             = 4,
  parameter int VC_W          = 2,
  parameter int D_W           = 8,
  parameter int VC_FIFO_DEPTH = 4,
  localparam int A_W   = $clog2(N) + 1,
  localparam int VCI_W = (VC_W > 1) ? $clog2(VC_W) : 1,
  localparam int CR_W  = $clog2(VC_FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       in_dest,
  input  logic [D_W-1:0]       in_data,
  input  logic [VCI_W-1:0]     in_vc,
  output logic [VC_W-1:0]      tx_vc_target,
  output logic [A_W+D_W-1:0]   tx_packet,
  input  logic [VC_W-1:0]      tx_vc_credit_gnt,
`ifdef NOC_INJ_STATS_EN
  output logic                 cred_err,
  output logic [31:0]          stat_sent,
  output logic [31:0]          stat_stall
`else
  output logic                 cred_err
`endif
);

  localparam logic [CR_W-1:0] CR_MAX = CR_W'(VC_FIFO_DEPTH - 1);

  typedef struct packed {
    logic [VCI_W-1:0] vc;
    logic [A_W-1:0]   dest;
    logic [D_W-1:0]   data;
  } entry_t;

  entry_t          mem [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;
  logic [CR_W-1:0] credit [VC_W];

  entry_t          in_entry, head;
  logic            empty, full, push, send;
  logic [CR_W-1:0] head_cr;
  logic [VC_W-1:0] head_onehot, take;

  assign in_entry = {in_vc, in_dest, in_data};
  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign in_ready = rst & ~full;
  assign push     = in_valid & in_ready;

  // When empty the incoming entry is the head, giving single-cycle fall-through.
  assign head = empty ? in_entry : mem[rd_ptr];

  // An illegal vc matches no counter, reads zero credit and therefore never sends.
  always_comb begin
    head_cr     = '0;
    head_onehot = '0;
    for (int v = 0; v < VC_W; v++) begin
      if (head.vc == VCI_W'(v)) begin
        head_cr        = credit[v];
        head_onehot[v] = 1'b1;
      end
    end
  end

  assign send = (~empty | push) & (head_cr != '0);
  assign take = send ? head_onehot : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  // A bypassed entry is written and popped together, so pointers stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (send) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, send};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_vc_target <= '0;
      tx_packet    <= '0;
    end else begin
      tx_vc_target <= take;
      if (send) tx_packet <= {head.dest, head.data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_W; v++) credit[v] <= CR_MAX;
      cred_err <= 1'b0;
    end else begin
      for (int v = 0; v < VC_W; v++) begin
        if (tx_vc_credit_gnt[v] && !take[v]) begin
          if (credit[v] == CR_MAX) cred_err <= 1'b1;
          else                     credit[v] <= credit[v] + CR_W'(1);
        end else if (take[v] && !tx_vc_credit_gnt[v]) begin
          credit[v] <= credit[v] - CR_W'(1);
        end
      end
    end
  end

`ifdef NOC_INJ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_sent  <= '0;
      stat_stall <= '0;
    end else begin
      if (send)           stat_sent  <= stat_sent + 32'd1;
      if (!empty && !send) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
